// File: rtl/avm_exer_pkg.sv
// Shared types and constants for the Avalon-MM register exerciser:
// FSM state encoding, LFSR polynomial, byteenable schedule and reset value.
package avm_exer_pkg;

  // Encoding is visible on fail_exp_o/fail_got_o after a watchdog timeout.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    LAT  = 3'd4,
    CMP  = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [31:0] LFSR_POLY           = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_RESET_VALUE = 32'h1234_5678;

  // Entry i occupies bits [4*i +: 4]; listed here from entry 7 down to entry 0.
  localparam logic [31:0] BE_SEQ = {4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1, 4'hF};

  function automatic logic [31:0] lfsrNext(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/avm_reg_exerciser_lfsr32.sv
// lfsr32: 32-bit Galois LFSR (shift right) with seed load and a guard that
// keeps the register out of the all-zero lock-up state.
module lfsr32
  import avm_exer_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  localparam logic [31:0] SAFE_SEED = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      value <= SAFE_SEED;
    end else if (load) begin
      value <= (seed == 32'h0) ? SAFE_SEED : seed;
    end else if (advance) begin
      value <= lfsrNext(value);
    end
  end

endmodule

// File: rtl/avm_reg_exerciser.sv
// avm_reg_exerciser: Avalon-MM master running write/readback passes against one register.
// Optional waitrequest watchdog enabled by defining AVM_REG_EXERCISER_TIMEOUT_EN.
module avm_reg_exerciser
  import avm_exer_pkg::*;
#(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned TARGET_ADDR  = 0,
  parameter logic [31:0] RESET_VALUE  = DEFAULT_RESET_VALUE,
  parameter bit          CHECK_RESET  = 1'b1,
  parameter int unsigned NUM_ITER     = 256,
  parameter int unsigned READ_LATENCY = 0,
  parameter logic [31:0] SEED         = 32'h1
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              start_i,
  input  logic [31:0]       seed_i,
  output logic [ADDR_W-1:0] avm_M_address,
  output logic [31:0]       avm_M_writedata,
  output logic [3:0]        avm_M_byteenable,
  output logic              avm_M_write,
  output logic              avm_M_read,
  input  logic [31:0]       avm_M_readdata,
  input  logic              avm_M_waitrequest,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_cnt_o,
  output logic [31:0]       fail_exp_o,
  output logic [31:0]       fail_got_o
);

  localparam bit          LAT_ZERO  = (READ_LATENCY == 0);
  localparam logic [2:0]  LAT_LAST  = 3'(READ_LATENCY);
  localparam logic [15:0] LAST_ITER = 16'(NUM_ITER - 1);

  state_t      state, nextState;
  logic [15:0] iterCnt;
  logic        rd0Phase;
  logic [2:0]  latCnt;
  logic [31:0] rdData;
  logic [31:0] shadow;
  logic [31:0] lfsrVal;
  logic [15:0] errCnt;
  logic [31:0] failExp, failGot;
  logic        doneReg;
  logic        startAcc, xferAcc, timeout;
  logic [3:0]  curBe;
  logic        cmpValid;
  logic [31:0] cmpGot;
  logic        errEvent;
  logic [31:0] errExp, errGot;

  // Bus outputs decode from the state register alone, so an asynchronous
  // reset drops the strobes in the same cycle.
  assign curBe            = BE_SEQ[{iterCnt[2:0], 2'b00} +: 4];
  assign avm_M_address    = ADDR_W'(TARGET_ADDR);
  assign avm_M_write      = (state == WR);
  assign avm_M_read       = (state == RD0) || (state == RD);
  assign avm_M_writedata  = avm_M_write ? lfsrVal : 32'h0;
  assign avm_M_byteenable = avm_M_write ? curBe : 4'h0;

  assign xferAcc  = (avm_M_write || avm_M_read) && !avm_M_waitrequest;
  assign startAcc = (state == IDLE) && start_i;

  assign busy_o     = (state != IDLE) && (state != FIN);
  assign done_o     = doneReg;
  assign pass_o     = doneReg && (errCnt == 16'd0);
  assign err_cnt_o  = errCnt;
  assign fail_exp_o = failExp;
  assign fail_got_o = failGot;

  lfsr32 #(.SEED(SEED)) uLfsr (
    .csi_MCLK_clk   (csi_MCLK_clk),
    .rsi_MRST_reset (rsi_MRST_reset),
    .load           (startAcc),
    .seed           (seed_i),
    .advance        (avm_M_write && xferAcc),
    .value          (lfsrVal)
  );

`ifdef AVM_REG_EXERCISER_TIMEOUT_EN
  logic [15:0] wdCnt;
  logic        stall;

  assign stall   = (avm_M_write || avm_M_read) && avm_M_waitrequest;
  assign timeout = stall && (wdCnt == 16'hFFFF);

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      wdCnt <= 16'd0;
    end else if (!stall) begin
      wdCnt <= 16'd0;
    end else if (!timeout) begin
      wdCnt <= wdCnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // The reset readback with zero latency is checked in its accept cycle;
  // every other readback goes through the registered CMP state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cmpValid = 1'b0;
    cmpGot   = rdData;
    if (state == CMP) begin
      cmpValid = 1'b1;
    end else if ((state == RD0) && LAT_ZERO && xferAcc) begin
      cmpValid = 1'b1;
      cmpGot   = avm_M_readdata;
    end
  end

  assign errEvent = timeout || (cmpValid && (cmpGot != shadow));
  assign errExp   = timeout ? {16'hDEAD, 13'd0, state} : shadow;
  assign errGot   = timeout ? {16'hDEAD, 13'd0, state} : cmpGot;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (start_i) nextState = CHECK_RESET ? RD0 : WR;
      RD0:  if (xferAcc) nextState = LAT_ZERO ? WR : LAT;
      WR:   if (xferAcc) nextState = RD;
      RD:   if (xferAcc) nextState = LAT_ZERO ? CMP : LAT;
      LAT:  if (latCnt == LAT_LAST) nextState = CMP;
      CMP: begin
        if (rd0Phase) begin
          nextState = WR;
        end else if (iterCnt == LAST_ITER) begin
          nextState = FIN;
        end else begin
          nextState = WR;
        end
      end
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (timeout) nextState = FIN;
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rsi_MRST_reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      iterCnt  <= 16'd0;
      rd0Phase <= 1'b0;
      latCnt   <= 3'd0;
      rdData   <= 32'h0;
      shadow   <= RESET_VALUE;
      errCnt   <= 16'd0;
      failExp  <= 32'h0;
      failGot  <= 32'h0;
      doneReg  <= 1'b0;
    end else if (startAcc) begin
      iterCnt  <= 16'd0;
      rd0Phase <= CHECK_RESET;
      shadow   <= RESET_VALUE;
      errCnt   <= 16'd0;
      failExp  <= 32'h0;
      failGot  <= 32'h0;
      doneReg  <= 1'b0;
    end else begin
      if (avm_M_write && xferAcc) begin
        for (int k = 0; k < 4; k++) begin
          if (curBe[k]) shadow[8*k +: 8] <= lfsrVal[8*k +: 8];
        end
      end

      if (avm_M_read && xferAcc) begin
        latCnt <= 3'd1;
        rdData <= avm_M_readdata;
        if ((state == RD0) && LAT_ZERO) rd0Phase <= 1'b0;
      end

      if (state == LAT) begin
        latCnt <= latCnt + 3'd1;
        if (latCnt == LAT_LAST) rdData <= avm_M_readdata;
      end

      if (state == CMP) begin
        if (rd0Phase) begin
          rd0Phase <= 1'b0;
        end else begin
          iterCnt <= iterCnt + 16'd1;
        end
      end

      // The first error latches its context; later errors only count.
      if (errEvent) begin
        if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
        if (errCnt == 16'd0) begin
          failExp <= errExp;
          failGot <= errGot;
        end
      end

      if (nextState == FIN) doneReg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avm_reg_exerciser.sv
// Self-checking bench for avm_reg_exerciser: zero-latency and 2-cycle-latency
// register slave models, write scoreboard, stall-stability monitor.
`timescale 1ns/1ps
module tb_avm_reg_exerciser;

  localparam logic [31:0] RST_VAL = 32'h1234_5678;
  localparam logic [31:0] POLY    = 32'h8020_0003;
  localparam int          N_ITER  = 8;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic        start1 = 1'b0, start2 = 1'b0;
  logic [31:0] seed1 = 32'h0, seed2 = 32'h0;
  logic [1:0]  addr1, addr2;
  logic [31:0] wdata1, wdata2, rdata1, rdata2;
  logic [3:0]  be1, be2;
  logic        wr1, wr2, rd1, rd2;
  logic        wreq1 = 1'b0;
  logic        wreq2 = 1'b0;
  logic        busy1, busy2, done1, done2, pass1, pass2;
  logic [15:0] err1, err2;
  logic [31:0] fexp1, fexp2, fgot1, fgot2;

  avm_reg_exerciser #(.NUM_ITER(N_ITER), .READ_LATENCY(0)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .start_i(start1), .seed_i(seed1),
    .avm_M_address(addr1), .avm_M_writedata(wdata1), .avm_M_byteenable(be1),
    .avm_M_write(wr1), .avm_M_read(rd1), .avm_M_readdata(rdata1),
    .avm_M_waitrequest(wreq1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_cnt_o(err1), .fail_exp_o(fexp1), .fail_got_o(fgot1)
  );

  avm_reg_exerciser #(.NUM_ITER(N_ITER), .READ_LATENCY(2)) dutLat (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .start_i(start2), .seed_i(seed2),
    .avm_M_address(addr2), .avm_M_writedata(wdata2), .avm_M_byteenable(be2),
    .avm_M_write(wr2), .avm_M_read(rd2), .avm_M_readdata(rdata2),
    .avm_M_waitrequest(wreq2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .fail_exp_o(fexp2), .fail_got_o(fgot2)
  );

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] modelNext(input logic [31:0] c);
    logic [31:0] n;
    n = c >> 1;
    if (c[0]) n = n ^ POLY;
    return n;
  endfunction

  function automatic logic [3:0] beOf(input int i);
    case (i % 8)
      0: return 4'hF;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'h4;
      4: return 4'h8;
      5: return 4'h3;
      6: return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // ---------------- slave models ----------------
  logic        slvInit = 1'b0;
  logic        randWait = 1'b0;
  logic        forceWait = 1'b0;
  logic [31:0] stuckMask = 32'hFFFF_FFFF;
  logic [31:0] slvReg1 = RST_VAL;
  logic [31:0] slvReg2 = RST_VAL;
  logic        pipeV = 1'b0;
  logic [31:0] pipeD = 32'h0;
  logic [31:0] rdPipe = 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (slvInit) slvReg1 <= RST_VAL;
    else if (wr1 && !wreq1) slvReg1 <= mergeBe(slvReg1, wdata1, be1);
    wreq1 <= forceWait || (randWait && ($urandom_range(0, 1) == 1));
  end
  assign rdata1 = slvReg1 & stuckMask;

  // Fixed latency 2: data is valid only in the second cycle after accept.
  always @(posedge clk) begin
    if (slvInit) slvReg2 <= RST_VAL;
    else if (wr2) slvReg2 <= mergeBe(slvReg2, wdata2, be2);
    pipeV  <= rd2;
    pipeD  <= slvReg2;
    rdPipe <= pipeV ? pipeD : 32'hBAD0_BAD0;
  end
  assign rdata2 = rdPipe;

  // ---------------- scoreboard / monitors ----------------
  wr_t        q1[$];
  wr_t        q2[$];
  wr_t        e1, e2;
  int         wrCnt1 = 0;
  logic       stallPend = 1'b0;
  logic [39:0] stallSnap = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr1 && !wreq1) begin
        if (q1.size() == 0) begin
          nFails++;
          $display("FAIL wr1_unexpected got data=%h be=%h, no write expected", wdata1, be1);
        end else begin
          e1 = q1.pop_front();
          if ({wdata1, be1} !== {e1.data, e1.be}) begin
            nFails++;
            $display("FAIL wr1_data got %h/%h required %h/%h", wdata1, be1, e1.data, e1.be);
          end
        end
        nChecks++;
        wrCnt1++;
      end
      if (wr1 || rd1) begin
        if (wr1 && rd1) begin
          nFails++;
          $display("FAIL strobe_excl got write=1 read=1 required one strobe");
        end
        nChecks++;
      end
      if (stallPend) begin
        if ({wr1, rd1, addr1, wdata1, be1} !== stallSnap) begin
          nFails++;
          $display("FAIL stall_stable got %h required %h", {wr1, rd1, addr1, wdata1, be1}, stallSnap);
        end
        nChecks++;
      end
      stallPend = (wr1 || rd1) && wreq1;
      stallSnap = {wr1, rd1, addr1, wdata1, be1};

      if (wr2) begin
        if (q2.size() == 0) begin
          nFails++;
          $display("FAIL wr2_unexpected got data=%h be=%h, no write expected", wdata2, be2);
        end else begin
          e2 = q2.pop_front();
          if ({wdata2, be2} !== {e2.data, e2.be}) begin
            nFails++;
            $display("FAIL wr2_data got %h/%h required %h/%h", wdata2, be2, e2.data, e2.be);
          end
        end
        nChecks++;
      end
    end else begin
      stallPend = 1'b0;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  // Pushes the expected writes and predicts error count and first mismatch.
  task automatic planRun(input int sel, input logic [31:0] seed, input logic [31:0] mask,
                         output int expErr, output logic [31:0] fExp, output logic [31:0] fGot);
    logic [31:0] lf, regv, shd;
    wr_t w;
    lf = (seed == 32'h0) ? 32'h1 : seed;
    regv = RST_VAL;
    shd = RST_VAL;
    expErr = 0;
    fExp = 32'h0;
    fGot = 32'h0;
    if ((regv & mask) != shd) begin
      expErr = 1;
      fExp = shd;
      fGot = regv & mask;
    end
    for (int i = 0; i < N_ITER; i++) begin
      w.data = lf;
      w.be = beOf(i);
      if (sel == 1) q1.push_back(w);
      else q2.push_back(w);
      regv = mergeBe(regv, lf, w.be);
      shd = mergeBe(shd, lf, w.be);
      lf = modelNext(lf);
      if ((regv & mask) != shd) begin
        if (expErr == 0) begin
          fExp = shd;
          fGot = regv & mask;
        end
        expErr++;
      end
    end
  endtask

  task automatic initSlaves;
    @(negedge clk);
    slvInit = 1'b1;
    @(negedge clk);
    slvInit = 1'b0;
  endtask

  task automatic startRun(input int sel, input logic [31:0] seed);
    @(negedge clk);
    if (sel == 1) begin
      seed1 = seed;
      start1 = 1'b1;
    end else begin
      seed2 = seed;
      start2 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Cycles counted from the accepting edge until done is seen (bounded).
  task automatic waitDone(input int sel, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!((sel == 1) ? done1 : done2) && cyc < budget);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if ({wr1, rd1} !== 2'b00) begin
      nFails++; $display("FAIL reset_strobes got %b required 00", {wr1, rd1});
    end
    nChecks++;
    if ({busy1, done1, pass1} !== 3'b000) begin
      nFails++; $display("FAIL reset_status got %b required 000", {busy1, done1, pass1});
    end
    nChecks++;
    if (err1 !== 16'h0 || fexp1 !== 32'h0 || fgot1 !== 32'h0) begin
      nFails++; $display("FAIL reset_errs got %h %h %h required zeros", err1, fexp1, fgot1);
    end
    nChecks++;
    if (wdata1 !== 32'h0 || be1 !== 4'h0 || addr1 !== 2'd0) begin
      nFails++; $display("FAIL reset_bus got %h %h %h required zeros", wdata1, be1, addr1);
    end
    nChecks++;
    if ({busy2, done2, wr2, rd2} !== 4'b0000) begin
      nFails++; $display("FAIL reset_dut2 got %b required 0000", {busy2, done2, wr2, rd2});
    end
    nChecks++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int expErr, cyc;
    logic [31:0] fe, fg;
    planRun(1, 32'h1, 32'hFFFF_FFFF, expErr, fe, fg);
    initSlaves();
    startRun(1, 32'h1);
    waitDone(1, 200, cyc);
    if (cyc !== 25) begin
      nFails++; $display("FAIL basic_latency got %0d cycles required 25", cyc);
    end
    nChecks++;
    if ({done1, pass1, busy1} !== 3'b110) begin
      nFails++; $display("FAIL basic_status got done/pass/busy=%b required 110", {done1, pass1, busy1});
    end
    nChecks++;
    if (err1 !== 16'(expErr)) begin
      nFails++; $display("FAIL basic_err got %0d required %0d", err1, expErr);
    end
    nChecks++;
    if (q1.size() !== 0) begin
      nFails++; $display("FAIL basic_writes got %0d unissued required 0", q1.size());
    end
    nChecks++;
  endtask

  task automatic test_stuck_lane;
    int expErr, cyc;
    logic [31:0] fe, fg;
    stuckMask = 32'hFF00_FFFF;
    planRun(1, 32'hFFFF_FFFF, stuckMask, expErr, fe, fg);
    initSlaves();
    startRun(1, 32'hFFFF_FFFF);
    waitDone(1, 200, cyc);
    stuckMask = 32'hFFFF_FFFF;
    if ({done1, pass1} !== 2'b10) begin
      nFails++; $display("FAIL stuck_status got done/pass=%b required 10", {done1, pass1});
    end
    nChecks++;
    if (err1 !== 16'(expErr)) begin
      nFails++; $display("FAIL stuck_err got %0d required %0d", err1, expErr);
    end
    nChecks++;
    if (fexp1 !== 32'h1234_5678 || fexp1 !== fe) begin
      nFails++; $display("FAIL stuck_fail_exp got %h required %h", fexp1, fe);
    end
    nChecks++;
    if (fgot1 !== 32'h1200_5678 || fgot1 !== fg) begin
      nFails++; $display("FAIL stuck_fail_got got %h required %h", fgot1, fg);
    end
    nChecks++;
  endtask

  task automatic test_waitrequest;
    int expErr, cyc;
    logic [31:0] fe, fg;
    planRun(1, 32'h1, 32'hFFFF_FFFF, expErr, fe, fg);
    initSlaves();
    randWait = 1'b1;
    startRun(1, 32'h1);
    waitDone(1, 3000, cyc);
    randWait = 1'b0;
    if ({done1, pass1} !== 2'b11) begin
      nFails++; $display("FAIL wait_status got done/pass=%b required 11 after %0d cycles", {done1, pass1}, cyc);
    end
    nChecks++;
    if (err1 !== 16'(expErr) || q1.size() !== 0) begin
      nFails++; $display("FAIL wait_result got err=%0d left=%0d required %0d/0", err1, q1.size(), expErr);
    end
    nChecks++;
  endtask

  task automatic test_read_latency;
    int expErr, cyc;
    logic [31:0] fe, fg;
    planRun(2, 32'h5A5A_0001, 32'hFFFF_FFFF, expErr, fe, fg);
    initSlaves();
    startRun(2, 32'h5A5A_0001);
    waitDone(2, 400, cyc);
    if (cyc !== 44) begin
      nFails++; $display("FAIL lat_latency got %0d cycles required 44", cyc);
    end
    nChecks++;
    if ({done2, pass2} !== 2'b11 || err2 !== 16'(expErr)) begin
      nFails++; $display("FAIL lat_result got done/pass=%b err=%0d required 11/%0d", {done2, pass2}, err2, expErr);
    end
    nChecks++;
    if (q2.size() !== 0) begin
      nFails++; $display("FAIL lat_writes got %0d unissued required 0", q2.size());
    end
    nChecks++;
  endtask

  task automatic test_busy_start_and_reset;
    int expErr, cyc, base, n;
    logic [31:0] fe, fg;
    planRun(1, 32'h1, 32'hFFFF_FFFF, expErr, fe, fg);
    initSlaves();
    startRun(1, 32'h1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5) begin
        if (busy1 !== 1'b1) begin
          nFails++; $display("FAIL busy_mid_run got %b required 1", busy1);
        end
        nChecks++;
        seed1 = 32'hABCD_EF01;
        start1 = 1'b1;
      end
      if (cyc == 6) start1 = 1'b0;
    end while (!done1 && cyc < 200);
    if (cyc !== 25 || pass1 !== 1'b1 || q1.size() !== 0) begin
      nFails++; $display("FAIL busy_start_ignored got cyc=%0d pass=%b left=%0d required 25/1/0", cyc, pass1, q1.size());
    end
    nChecks++;

    planRun(1, 32'h0000_BEEF, 32'hFFFF_FFFF, expErr, fe, fg);
    initSlaves();
    base = wrCnt1;
    startRun(1, 32'h0000_BEEF);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (wrCnt1 < base + 3 && n < 100);
    if (rd1 !== 1'b1 || busy1 !== 1'b1) begin
      nFails++; $display("FAIL midrun_read got read=%b busy=%b required 1/1", rd1, busy1);
    end
    nChecks++;
    rst = 1'b1;
    #1;
    if ({wr1, rd1} !== 2'b00 || wdata1 !== 32'h0 || be1 !== 4'h0) begin
      nFails++; $display("FAIL midrun_strobes got %b %h %h required zeros", {wr1, rd1}, wdata1, be1);
    end
    nChecks++;
    if ({busy1, done1, pass1} !== 3'b000 || err1 !== 16'h0) begin
      nFails++; $display("FAIL midrun_status got %b err=%0d required 000/0", {busy1, done1, pass1}, err1);
    end
    nChecks++;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    repeat (2) @(negedge clk);
    if ({busy1, done1, wr1, rd1} !== 4'b0000) begin
      nFails++; $display("FAIL after_reset got %b required 0000", {busy1, done1, wr1, rd1});
    end
    nChecks++;
  endtask

`ifdef AVM_REG_EXERCISER_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    forceWait = 1'b1;
    startRun(1, 32'h1);
    waitDone(1, 70000, cyc);
    forceWait = 1'b0;
    if ({done1, pass1} !== 2'b10 || err1 !== 16'd1) begin
      nFails++; $display("FAIL timeout_status got done/pass=%b err=%0d required 10/1", {done1, pass1}, err1);
    end
    nChecks++;
    if (fexp1 !== 32'hDEAD_0001 || fgot1 !== 32'hDEAD_0001) begin
      nFails++; $display("FAIL timeout_fail got %h/%h required DEAD0001", fexp1, fgot1);
    end
    nChecks++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stuck_lane();
    test_waitrequest();
    test_read_latency();
    test_busy_start_and_reset();
`ifdef AVM_REG_EXERCISER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
